// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one uart_tx among NUM_REQ requesters.
// Each grant owns a fixed-length frame slot timed locally, since uart_tx reports no busy/done.
module uart_tx_scheduler #(
  parameter int CLK_FREQUENCY = 50_000_000,
  parameter int BAUD_RATE     = 115_200,
  parameter int DATA_BITS     = 7,
  parameter int NUM_REQ       = 4,
  parameter int GUARD_BITS    = 1,
  localparam int ID_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [DATA_BITS-1:0]           data_to_transmit,
  output logic                           request_to_send,
  output logic                           busy,
  output logic [ID_W-1:0]                grant_id,
  output logic                           frame_done
);

  localparam int BAUD_DIVIDER = CLK_FREQUENCY / BAUD_RATE;
  localparam int SLOT_CYCLES  = (DATA_BITS + 2 + GUARD_BITS) * BAUD_DIVIDER;
  localparam int CNT_W        = $clog2(SLOT_CYCLES);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] SEND_LAST = CNT_W'(BAUD_DIVIDER - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DONE_PRE  = CNT_W'(SLOT_CYCLES - 2);

  generate
    if (BAUD_DIVIDER < 2) begin : g_bad_baud
      $error("uart_tx_scheduler: BAUD_DIVIDER must be at least 2");
    end
    if (NUM_REQ < 1) begin : g_bad_num_req
      $error("uart_tx_scheduler: NUM_REQ must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t                 state_r;
  state_t                 state_next_s;
  logic [CNT_W-1:0]       cnt_r;
  logic [CNT_W-1:0]       cnt_next_s;
  logic [ID_W-1:0]        rr_ptr_r;
  logic [ID_W-1:0]        winner_s;
  logic [ID_W-1:0]        idx_s;
  logic                   found_s;
  logic                   grant_s;
  logic [DATA_BITS-1:0]   words_s [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
    assign words_s[g] = req_data[g*DATA_BITS +: DATA_BITS];
  end

  // Round-robin search starting one past the previous winner.
  always_comb begin
    found_s  = 1'b0;
    winner_s = rr_ptr_r;
    idx_s    = {ID_W{1'b0}};
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx_s = ID_W'((int'(rr_ptr_r) + k) % NUM_REQ);
      if (!found_s && req_valid[idx_s]) begin
        found_s  = 1'b1;
        winner_s = idx_s;
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Next-state, slot counter and grant strobe.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    grant_s      = 1'b0;
    req_ready    = {NUM_REQ{1'b0}};
    case (state_r)
      IDLE: begin
        if (found_s) begin
          grant_s             = 1'b1;
          req_ready[winner_s] = ~reset;
          state_next_s        = SEND;
          cnt_next_s          = CNT_ZERO;
        end else begin
          state_next_s        = IDLE;
        end
      end
      SEND: begin
        cnt_next_s = cnt_r + CNT_ONE;
        if (cnt_r == SEND_LAST) begin
          state_next_s = WAIT;
        end else begin
          state_next_s = SEND;
        end
      end
      WAIT: begin
        if (cnt_r == SLOT_LAST) begin
          state_next_s = IDLE;
          cnt_next_s   = CNT_ZERO;
        end else begin
          state_next_s = WAIT;
          cnt_next_s   = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = CNT_ZERO;
      end
    endcase
  end

  // State register, counter and registered outputs; frame_done is set one cycle early so it lands on the last slot cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r          <= IDLE;
      cnt_r            <= CNT_ZERO;
      rr_ptr_r         <= ID_W'(NUM_REQ - 1);
      data_to_transmit <= {DATA_BITS{1'b0}};
      request_to_send  <= 1'b0;
      busy             <= 1'b0;
      grant_id         <= {ID_W{1'b0}};
      frame_done       <= 1'b0;
    end else begin
      state_r          <= state_next_s;
      cnt_r            <= cnt_next_s;
      request_to_send  <= (state_next_s == SEND);
      busy             <= (state_next_s != IDLE);
      frame_done       <= (state_r == WAIT) && (cnt_r == DONE_PRE);
      if (grant_s) begin
        data_to_transmit <= words_s[winner_s];
        grant_id         <= winner_s;
        rr_ptr_r         <= winner_s;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Randomized bench for uart_tx_scheduler, checked every cycle against a slot-timing reference model,
// plus directed scenarios for reset, single request, continuous load, fairness, mid-slot reset and withdrawal.
module tb_uart_tx_scheduler;

  localparam int CLK_F = 1_000_000;
  localparam int BAUD  = 62_500;
  localparam int DB    = 7;
  localparam int N     = 4;
  localparam int GB    = 1;
  localparam int BD    = CLK_F / BAUD;
  localparam int SLOT  = (DB + 2 + GB) * BD;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*DB-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic [DB-1:0]   data_to_transmit;
  logic            request_to_send;
  logic            busy;
  logic [1:0]      grant_id;
  logic            frame_done;

  always #5 clk = ~clk;

  uart_tx_scheduler #(
    .CLK_FREQUENCY(CLK_F),
    .BAUD_RATE(BAUD),
    .DATA_BITS(DB),
    .NUM_REQ(N),
    .GUARD_BITS(GB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .data_to_transmit(data_to_transmit),
    .request_to_send(request_to_send),
    .busy(busy),
    .grant_id(grant_id),
    .frame_done(frame_done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // stimulus state: pending requests hold their word until granted
  logic          rst_cmd;
  logic [N-1:0]  pend;
  logic [N-1:0]  hold_mask;
  logic [DB-1:0] words [N];

  // reference model: slot age in cycles since the grant edge
  logic          m_busy;
  int            m_t;
  logic [DB-1:0] m_data;
  int            m_gid;
  int            m_ptr;

  // observation of the DUT
  int            cyc;
  logic          prev_rts;
  int            ready_cnt, rts_cnt, busy_cnt, fd_cnt, fd_at;
  logic [N-1:0]  ready_seen;
  int            rise_q[$];
  int            gid_q[$];
  logic [DB-1:0] data_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int ptr);
    int idx;
    for (int k = 1; k <= N; k++) begin
      idx = (ptr + k) % N;
      if (v[2'(idx)]) return idx;
    end
    return -1;
  endfunction

  task automatic raise(input logic [1:0] i);
    pend[i]  = 1'b1;
    words[i] = DB'($urandom);
  endtask

  task automatic refill();
    for (int i = 0; i < N; i++) begin
      if (hold_mask[2'(i)] && !pend[2'(i)]) raise(2'(i));
    end
  endtask

  task automatic clear_mon();
    ready_cnt = 0; rts_cnt = 0; busy_cnt = 0; fd_cnt = 0; fd_at = 0;
    ready_seen = 4'b0000;
    rise_q.delete(); gid_q.delete(); data_q.delete();
  endtask

  // one clock cycle: apply inputs, compare against the model, then advance the model across the edge
  task automatic step();
    logic [N-1:0] exp_ready;
    int w;
    @(posedge clk); #1;
    reset     = rst_cmd;
    req_valid = pend;
    req_data  = {words[3], words[2], words[1], words[0]};
    #1;
    cyc++;
    w = -1;
    if (!rst_cmd && !m_busy) w = pick(pend, m_ptr);
    exp_ready = 4'b0000;
    if (w >= 0) exp_ready[2'(w)] = 1'b1;
    check_eq("req_ready",  32'(req_ready),        32'(exp_ready));
    check_eq("busy",       32'(busy),             32'(m_busy));
    check_eq("rts",        32'(request_to_send),  32'(m_busy && m_t <= BD));
    check_eq("frame_done", 32'(frame_done),       32'(m_busy && m_t == SLOT));
    check_eq("data",       32'(data_to_transmit), 32'(m_data));
    check_eq("grant_id",   32'(grant_id),         32'(m_gid));

    if (|req_ready) begin ready_cnt++; ready_seen = ready_seen | req_ready; end
    if (request_to_send) rts_cnt++;
    if (busy) busy_cnt++;
    if (frame_done) begin fd_cnt++; fd_at = busy_cnt; end
    if (request_to_send && !prev_rts) begin
      rise_q.push_back(cyc);
      gid_q.push_back(int'(grant_id));
      data_q.push_back(data_to_transmit);
    end
    prev_rts = request_to_send;

    if (rst_cmd) begin
      m_busy = 1'b0; m_t = 0; m_data = 7'd0; m_gid = 0; m_ptr = N - 1;
    end else if (!m_busy) begin
      if (w >= 0) begin
        m_busy = 1'b1; m_t = 1; m_data = words[2'(w)]; m_gid = w; m_ptr = w;
        pend[2'(w)] = 1'b0;
      end
    end else if (m_t == SLOT) begin
      m_busy = 1'b0;
    end else begin
      m_t++;
    end
  endtask

  initial begin
    logic [DB-1:0] d0;
    logic [DB-1:0] exp_bits;
    exp_bits  = 7'h5A;
    reset     = 1'b1;
    req_valid = 4'b0000;
    req_data  = 28'd0;
    rst_cmd   = 1'b1;
    hold_mask = 4'b0000;
    pend      = 4'b0000;
    for (int i = 0; i < N; i++) raise(2'(i));
    m_busy = 1'b0; m_t = 0; m_data = 7'd0; m_gid = 0; m_ptr = N - 1;
    cyc = 0; prev_rts = 1'b0;
    clear_mon();

    // reset held with every requester pending
    repeat (2) step();
    check_eq("rst_ready", 32'(req_ready), 32'd0);
    check_eq("rst_busy",  32'(busy), 32'd0);
    check_eq("rst_rts",   32'(request_to_send), 32'd0);
    check_eq("rst_gid",   32'(grant_id), 32'd0);
    check_eq("rst_data",  32'(data_to_transmit), 32'd0);

    // continuous load: order 0,1,2,3,0,1 and slot period SLOT+1
    rst_cmd = 1'b0; hold_mask = 4'b1111; clear_mon();
    repeat (5 * (SLOT + 1) + 3) begin step(); refill(); end
    hold_mask = 4'b0000; pend = 4'b0000;
    check_eq("all_count", 32'(gid_q.size()), 32'd6);
    for (int k = 0; k < 6 && k < gid_q.size(); k++) check_eq("all_order", 32'(gid_q[k]), 32'(k % N));
    for (int k = 1; k < rise_q.size(); k++) check_eq("all_period", 32'(rise_q[k] - rise_q[k-1]), 32'(SLOT + 1));
    repeat (SLOT + 10) step();

    // single request from requester 2
    clear_mon();
    pend[2] = 1'b1; words[2] = 7'h5A;
    repeat (SLOT + 10) step();
    check_eq("one_ready_mask", 32'(ready_seen), 32'h4);
    check_eq("one_ready_cnt",  32'(ready_cnt), 32'd1);
    check_eq("one_rts_cnt",    32'(rts_cnt), 32'(BD));
    check_eq("one_busy_cnt",   32'(busy_cnt), 32'(SLOT));
    check_eq("one_fd_cnt",     32'(fd_cnt), 32'd1);
    check_eq("one_fd_last",    32'(fd_at), 32'(SLOT));
    check_eq("one_gid",        32'(gid_q.size() > 0 ? gid_q[0] : -1), 32'd2);
    d0 = (data_q.size() > 0) ? data_q[0] : 7'd0;
    for (int k = 0; k < DB; k++) check_eq("one_line_bit", 32'(d0[3'(k)]), 32'(exp_bits[3'(k)]));

    // fairness: after requester 1, pattern 1001 serves 3 then 0
    clear_mon();
    raise(2'd1);
    repeat (3) step();
    raise(2'd0); raise(2'd3);
    repeat (3 * (SLOT + 1) + 5) step();
    check_eq("rr_count", 32'(gid_q.size()), 32'd3);
    if (gid_q.size() == 3) begin
      check_eq("rr_first",  32'(gid_q[0]), 32'd1);
      check_eq("rr_second", 32'(gid_q[1]), 32'd3);
      check_eq("rr_third",  32'(gid_q[2]), 32'd0);
    end

    // reset in the middle of a slot (counter = 100)
    clear_mon();
    raise(2'd2);
    step();
    repeat (100) step();
    check_eq("mid_busy_before", 32'(busy), 32'd1);
    rst_cmd = 1'b1; raise(2'd0); raise(2'd1);
    step();
    rst_cmd = 1'b0;
    step();
    check_eq("mid_busy_after", 32'(busy), 32'd0);
    check_eq("mid_rts_after",  32'(request_to_send), 32'd0);
    check_eq("mid_no_fd",      32'(fd_cnt), 32'd0);
    repeat (2 * (SLOT + 1) + 5) step();
    check_eq("mid_count", 32'(gid_q.size()), 32'd3);
    if (gid_q.size() == 3) begin
      check_eq("mid_first_after", 32'(gid_q[1]), 32'd0);
      check_eq("mid_second_after", 32'(gid_q[2]), 32'd1);
    end

    // withdrawal of requester 1 during another slot's WAIT phase
    clear_mon();
    raise(2'd0);
    repeat (BD + 20) step();
    raise(2'd1);
    repeat (10) step();
    pend[1] = 1'b0;
    repeat (SLOT + 10) step();
    check_eq("wd_ready_mask", 32'(ready_seen), 32'h1);
    check_eq("wd_count",      32'(gid_q.size()), 32'd1);
    check_eq("wd_idle",       32'(busy), 32'd0);

    // random traffic with occasional withdrawals and resets
    repeat (3000) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[2'(i)] && ($urandom % 20) == 0) raise(2'(i));
        else if (pend[2'(i)] && ($urandom % 200) == 0) pend[2'(i)] = 1'b0;
      end
      if (rst_cmd) rst_cmd = 1'b0;
      else if (($urandom % 700) == 0) rst_cmd = 1'b1;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Round-robin scheduler that shares one `uart_tx` transmitter among `NUM_REQ` requesters. It arbitrates between pending requesters, captures the winner's word, and drives `uart_tx`'s `data_to_transmit` / `request_to_send` inputs. It owns the frame-slot timing itself, because `uart_tx` exposes no busy or done signal. It sits between the client blocks and the `uart_tx` instance, whose ports it connects to directly.

## Interface

Parameters:
- `CLK_FREQUENCY`, 50_000_000, system clock in Hz
- `BAUD_RATE`, 115_200, line rate in baud
- `DATA_BITS`, 7, data bits per frame; must equal `uart_tx`'s `DATA_BITS`
- `NUM_REQ`, 4, number of requesters; must be ≥1
- `GUARD_BITS`, 1, extra idle bit periods appended to each slot; must be ≥0

Derived localparams:
- `BAUD_DIVIDER` = `CLK_FREQUENCY / BAUD_RATE`, integer division (434 at defaults)
- `SLOT_CYCLES` = `(DATA_BITS + 2 + GUARD_BITS) * BAUD_DIVIDER` (4340 at defaults)
- Elaboration error if `BAUD_DIVIDER < 2`.

Ports:
- `clk`  in  1  single system clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `req_valid`  in  NUM_REQ  bit i: requester i has a word pending
- `req_data`  in  NUM_REQ*DATA_BITS  requester i's word in bits [i*DATA_BITS +: DATA_BITS]
- `req_ready`  out  NUM_REQ  one-hot grant/accept pulse; word captured on this edge
- `data_to_transmit`  out  DATA_BITS  to `uart_tx`; held for the whole slot
- `request_to_send`  out  1  to `uart_tx`
- `busy`  out  1  high while a slot is in progress
- `grant_id`  out  max(1,$clog2(NUM_REQ))  index of the requester owning the current slot
- `frame_done`  out  1  one-cycle pulse in the last cycle of a slot

## Operation

- FSM states: IDLE, SEND, WAIT.
- **IDLE**
  - If any `req_valid` bit is set, select a winner by round-robin.
  - Search order is `rr_ptr+1`, `rr_ptr+2`, … modulo `NUM_REQ`.
  - `req_ready[winner]` is high combinationally in this cycle only.
  - On the edge: capture `req_data[winner]`, set `rr_ptr` = winner, `grant_id` = winner, counter = 0, go to SEND.
- **SEND**
  - `request_to_send` = 1; the counter increments every cycle.
  - When counter = `BAUD_DIVIDER-1`, go to WAIT.
- **WAIT**
  - `request_to_send` = 0; the counter continues.
  - When counter = `SLOT_CYCLES-1`, pulse `frame_done` and go to IDLE.
- `busy` = 1 in SEND and WAIT.
- `data_to_transmit` and `grant_id` hold their values until the next grant.
- The counter is `$clog2(SLOT_CYCLES)` bits wide and never wraps inside a slot.
- `req_ready` is 0 outside IDLE and whenever `reset` is high.
- Requester rule: hold `req_valid` and data stable until `req_ready`. Withdrawal before a grant is tolerated; a withdrawn requester is never granted.
- `req_valid` is sampled only in IDLE. Changes during SEND/WAIT have no effect.
- Reset values:
  - state IDLE, counter 0
  - `data_to_transmit` 0, `request_to_send` 0, `busy` 0, `grant_id` 0, `frame_done` 0
  - `rr_ptr` = `NUM_REQ-1`, so requester 0 has first priority
- Reset during SEND/WAIT aborts the slot: all outputs reach their reset values on the next edge, and no `frame_done` is emitted.

## Timing

- Grant cycle T0 (IDLE, `req_ready` high).
- T1 to T0+`BAUD_DIVIDER`: `request_to_send` high, `busy` high, `data_to_transmit` valid. That is exactly `BAUD_DIVIDER` cycles, which guarantees `uart_tx` sees the request across at least one baud tick.
- T0+`SLOT_CYCLES`: `frame_done` high; `busy` still high.
- T0+`SLOT_CYCLES`+1: IDLE; the next grant can occur in this same cycle.
- Back-to-back slot period is `SLOT_CYCLES+1` cycles (4341 at defaults).
- Latency from `req_valid` rising in IDLE to `request_to_send` rising is 1 cycle.

## Test plan

- **Reset:** hold `reset` for 2 cycles with all `req_valid`=1111. Then `req_ready`=0000, `request_to_send`=0, `busy`=0, `grant_id`=0, `data_to_transmit`=0. On release, requester 0 is granted first.
- **Single request:** only `req_valid[2]`, data 7'h5A.
  - `req_ready`=0100 for 1 cycle.
  - Next cycle: `request_to_send`=1 for 434 cycles, `data_to_transmit`=7'h5A, `grant_id`=2.
  - `busy` high for 4340 cycles, `frame_done` in the last of them.
  - The attached `uart_tx` line shows start 0, then 0,1,0,1,1,0,1 LSB-first, then stop 1.
- **All requesters pending continuously:** grant order 0,1,2,3,0,1; rising edges of `request_to_send` spaced exactly 4341 cycles apart.
- **Round-robin fairness:** after requester 1 is served, with `req_valid`=1001, requester 3 wins, then requester 0.
- **Reset mid-slot:** assert `reset` at counter=1000. The next edge clears `busy` and `request_to_send` with no `frame_done`. After release with `req_valid`=0011, requester 0 wins.
- **Withdrawal:** `req_valid[1]` rises then falls during WAIT of another slot. Requester 1 is never granted, `req_ready[1]` never pulses, and the scheduler returns to IDLE with `busy`=0.
